// File: rtl/aespp_pkg.sv
// Shared constants for the AES-128 CBC-MAC post-processor: FSM encoding,
// zero-key round-key schedule and the lane-count helper.
package aespp_pkg;

    localparam int ROUND_CNT = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_MIX  = 2'd2,
        ST_DONE = 2'd3
    } aespp_state_e;

    localparam logic [127:0] RK0  = 128'h00000000000000000000000000000000;
    localparam logic [127:0] RK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] RK2  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
    localparam logic [127:0] RK3  = 128'h90973450696ccffaf2f457330b0fac99;
    localparam logic [127:0] RK4  = 128'hee06da7b876a1581759e42b27e91ee2b;
    localparam logic [127:0] RK5  = 128'h7f2e2b88f8443e098dda7cbbf34b9290;
    localparam logic [127:0] RK6  = 128'hec614b851425758c99ff09376ab49ba7;
    localparam logic [127:0] RK7  = 128'h217517873550620bacaf6b3cc61bf09b;
    localparam logic [127:0] RK8  = 128'h0ef903333ba9613897060a04511dfa9f;
    localparam logic [127:0] RK9  = 128'hb1d4d8e28a7db9da1d7bb3de4c664941;
    localparam logic [127:0] RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    function automatic int lane_cnt(input int lanes);
        return 16 / lanes;
    endfunction

    function automatic logic [127:0] rk_const(input logic [3:0] idx);
        logic [127:0] rk;
        case (idx)
            4'd0:    rk = RK0;
            4'd1:    rk = RK1;
            4'd2:    rk = RK2;
            4'd3:    rk = RK3;
            4'd4:    rk = RK4;
            4'd5:    rk = RK5;
            4'd6:    rk = RK6;
            4'd7:    rk = RK7;
            4'd8:    rk = RK8;
            4'd9:    rk = RK9;
            4'd10:   rk = RK10;
            default: rk = '0;
        endcase
        return rk;
    endfunction

endpackage

// File: rtl/aes_mix_columns_ref.sv
// AES MixColumns on a full 128-bit state, four independent columns.
module aes_mix_columns_ref (
    input  logic [127:0] i_state,
    output logic [127:0] o_state
);

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign a0 = i_state[127-32*c -: 8];
        assign a1 = i_state[119-32*c -: 8];
        assign a2 = i_state[111-32*c -: 8];
        assign a3 = i_state[103-32*c -: 8];
        assign o_state[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        assign o_state[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        assign o_state[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        assign o_state[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end

endmodule

// File: rtl/aes_sbox_canright_l1.sv
// AES forward S-box, combinational: GF(2^8) inverse (x^254) followed by the
// affine map. Zero maps to 0x63 because the inverse of zero is taken as zero.
module aes_sbox_canright_l1 (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] sq;
    logic [7:0] inv;

    // x^254 = product of x^2, x^4, ..., x^128
    always_comb begin
        sq  = i_byte;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        o_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                     ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

endmodule

// File: rtl/aes_shift_rows_ref.sv
// AES ShiftRows on a full 128-bit state; byte n = bits [127-8n -: 8],
// row = n%4, column = n/4.
module aes_shift_rows_ref (
    input  logic [127:0] i_state,
    output logic [127:0] o_state
);

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign o_state[127-8*(4*c+r) -: 8] = i_state[127-8*(4*((c+r)%4)+r) -: 8];
        end
    end

endmodule

// File: rtl/aespp_sub_lanes.sv
// SubBytes on one group of LANES bytes: bytes [grp*LANES +: LANES] are
// replaced by their S-box image, all other bytes pass through.
module aespp_sub_lanes
    import aespp_pkg::*;
#(
    parameter int LANES = 16
) (
    input  logic [127:0] i_state,
    input  logic [3:0]   i_grp,
    output logic [127:0] o_state
);

    logic [7:0] byte_in  [16];
    logic [7:0] lane_in  [LANES];
    logic [7:0] lane_out [LANES];

    for (genvar n = 0; n < 16; n++) begin : g_byte
        assign byte_in[n] = i_state[127-8*n -: 8];
        assign o_state[127-8*n -: 8] = (i_grp == 4'(n / LANES)) ? lane_out[n % LANES] : byte_in[n];
    end

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic [3:0] idx;
        assign idx        = 4'(int'(i_grp) * LANES + j);
        assign lane_in[j] = byte_in[idx];
        aes_sbox_canright_l1 u_sbox (
            .i_byte (lane_in[j]),
            .o_byte (lane_out[j])
        );
    end

endmodule

// File: rtl/aespp_cbcmac_core.sv
// AES-128 CBC-MAC conditioner with LANES S-boxes per SubBytes cycle.
// Optional writable round-key table: define AESPP_KEY_WR_EN.
module aespp_cbcmac_core
    import aespp_pkg::*;
#(
    parameter int LANES = 16,
    parameter int BLK_W = 4
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [127:0]     i_dat,
    input  logic [BLK_W-1:0] i_blocks,
    output logic             o_valid,
    input  logic             i_read,
    output logic [127:0]     o_dat,
    output logic             o_busy,
    input  logic             i_key_we,
    input  logic [3:0]       i_key_idx,
    input  logic [127:0]     i_key_dat,
    output logic [1:0]       o_dbg_state
);

    localparam int         N          = lane_cnt(LANES);
    localparam logic [3:0] GRP_LAST   = 4'(N - 1);
    localparam logic [3:0] ROUND_LAST = 4'(ROUND_CNT);

    aespp_state_e     state_q, state_d;
    logic [127:0]     aes_q, aes_d;
    logic [127:0]     chain_q, chain_d;
    logic [127:0]     dat_q, dat_d;
    logic [3:0]       round_q, round_d;
    logic [3:0]       grp_q, grp_d;
    logic [BLK_W-1:0] blk_q, blk_d;
    logic [BLK_W-1:0] blks_q, blks_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             armed_q;

    logic             accept;
    logic [3:0]       rk_idx;
    logic [127:0]     rk;
    logic [127:0]     sub_out, sr_out, mc_out, mix_res;

    // Input side: a word moves when i_valid & o_ready; output side: when o_valid & i_read.
    // o_ready is low for one cycle after reset and whenever an unread result is held.
    assign o_ready     = armed_q && (state_q == ST_IDLE) && (!valid_q || i_read);
    assign accept      = i_valid && o_ready;
    assign o_valid     = valid_q;
    assign o_dat       = dat_q;
    assign o_busy      = busy_q;
    assign o_dbg_state = state_q;

    assign rk_idx = (state_q == ST_MIX) ? round_q : 4'd0;

`ifdef AESPP_KEY_WR_EN
    logic [127:0] rk_q [11] = '{RK0, RK1, RK2, RK3, RK4, RK5, RK6, RK7, RK8, RK9, RK10};
    logic         key_wr;

    // Writes are refused once a chain has been accepted, so rk is fixed per chain.
    assign key_wr = i_key_we && (state_q == ST_IDLE) && !busy_q && !accept && (i_key_idx <= 4'd10);

    always_ff @(posedge i_clk) begin
        if (key_wr) rk_q[i_key_idx] <= i_key_dat;
    end

    assign rk = rk_q[rk_idx];
`else
    logic unused_key;
    assign unused_key = ^{i_key_we, i_key_idx, i_key_dat};
    assign rk         = rk_const(rk_idx);
`endif

    aespp_sub_lanes #(.LANES(LANES)) u_sub (
        .i_state (aes_q),
        .i_grp   (grp_q),
        .o_state (sub_out)
    );

    aes_shift_rows_ref u_sr (
        .i_state (aes_q),
        .o_state (sr_out)
    );

    aes_mix_columns_ref u_mc (
        .i_state (sr_out),
        .o_state (mc_out)
    );

    assign mix_res = ((round_q == ROUND_LAST) ? sr_out : mc_out) ^ rk;

    always_comb begin
        state_d = state_q;
        aes_d   = aes_q;
        chain_d = chain_q;
        dat_d   = dat_q;
        round_d = round_q;
        grp_d   = grp_q;
        blk_d   = blk_q;
        blks_d  = blks_q;
        valid_d = valid_q;
        busy_d  = busy_q;

        if (valid_q && i_read) valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    aes_d   = i_dat ^ (busy_q ? chain_q : 128'd0) ^ rk;
                    if (!busy_q) blks_d = i_blocks;
                    busy_d  = 1'b1;
                    round_d = 4'd1;
                    grp_d   = 4'd0;
                    state_d = ST_SUB;
                end
            end
            ST_SUB: begin
                aes_d = sub_out;
                if (grp_q == GRP_LAST) begin
                    grp_d   = 4'd0;
                    state_d = ST_MIX;
                end else begin
                    grp_d = grp_q + 4'd1;
                end
            end
            ST_MIX: begin
                aes_d = mix_res;
                if (round_q == ROUND_LAST) begin
                    if (blk_q == blks_q) begin
                        dat_d   = mix_res;
                        valid_d = 1'b1;
                        busy_d  = 1'b0;
                        blk_d   = '0;
                        chain_d = '0;
                        state_d = ST_DONE;
                    end else begin
                        chain_d = mix_res;
                        blk_d   = blk_q + 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    round_d = round_q + 4'd1;
                    state_d = ST_SUB;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            aes_q   <= '0;
            chain_q <= '0;
            dat_q   <= '0;
            round_q <= '0;
            grp_q   <= '0;
            blk_q   <= '0;
            blks_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            aes_q   <= aes_d;
            chain_q <= chain_d;
            dat_q   <= dat_d;
            round_q <= round_d;
            grp_q   <= grp_d;
            blk_q   <= blk_d;
            blks_q  <= blks_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            armed_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_aespp_cbcmac_core.sv
// Directed bench for aespp_cbcmac_core: three instances (LANES 16/4/1) share
// clock, reset and data; known-answer CBC-MAC values are hand-supplied.
module tb_aespp_cbcmac_core;

  localparam logic [127:0] ZK1 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] ZK2 = 128'hf795bd4a52e29ed713d313fa20e98dbc;

  logic         clk;
  logic         rst_n;
  logic [127:0] dat;
  logic [3:0]   blocks;
  logic         key_we;
  logic [3:0]   key_idx;
  logic [127:0] key_dat;
  logic         vld  [3];
  logic         rd   [3];
  logic         rdy  [3];
  logic         ovld [3];
  logic         busy [3];
  logic [127:0] odat [3];
  logic [1:0]   dbg  [3];

  logic [127:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  aespp_cbcmac_core #(.LANES(16), .BLK_W(4)) u_dut16 (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(vld[0]), .o_ready(rdy[0]), .i_dat(dat),
    .i_blocks(blocks), .o_valid(ovld[0]), .i_read(rd[0]), .o_dat(odat[0]), .o_busy(busy[0]),
    .i_key_we(key_we), .i_key_idx(key_idx), .i_key_dat(key_dat), .o_dbg_state(dbg[0])
  );

  aespp_cbcmac_core #(.LANES(4), .BLK_W(4)) u_dut4 (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(vld[1]), .o_ready(rdy[1]), .i_dat(dat),
    .i_blocks(blocks), .o_valid(ovld[1]), .i_read(rd[1]), .o_dat(odat[1]), .o_busy(busy[1]),
    .i_key_we(key_we), .i_key_idx(key_idx), .i_key_dat(key_dat), .o_dbg_state(dbg[1])
  );

  aespp_cbcmac_core #(.LANES(1), .BLK_W(4)) u_dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(vld[2]), .o_ready(rdy[2]), .i_dat(dat),
    .i_blocks(blocks), .o_valid(ovld[2]), .i_read(rd[2]), .o_dat(odat[2]), .o_busy(busy[2]),
    .i_key_we(key_we), .i_key_idx(key_idx), .i_key_dat(key_dat), .o_dbg_state(dbg[2])
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input int u);
    return (u == 0) ? 20 : ((u == 1) ? 50 : 170);
  endfunction

  // driver: present one word, wait (bounded) for o_ready, transfer on next edge
  task automatic send_word(input int u, input logic [127:0] d, input logic [3:0] b);
    int t = 0;
    dat    = d;
    blocks = b;
    vld[u] = 1'b1;
    #1;
    while (!rdy[u] && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    check("send_ready", 128'(rdy[u]), 128'(1));
    @(posedge clk); #1;
    vld[u] = 1'b0;
  endtask

  // scoreboard: wait for o_valid, compare latency and value against exp_q head
  task automatic wait_result(input int u, input int lat);
    int t = 0;
    logic [127:0] e;
    while (!ovld[u] && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    check("latency", 128'(t), 128'(lat));
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    check("mac", odat[u], e);
  endtask

  task automatic read_out(input int u);
    rd[u] = 1'b1;
    @(posedge clk); #1;
    rd[u] = 1'b0;
    check("read_drop", 128'(ovld[u]), 128'(0));
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int bad;
    logic [127:0] held;
`ifdef AESPP_KEY_WR_EN
    logic [127:0] c1_rk [11];
    c1_rk = '{128'h000102030405060708090a0b0c0d0e0f, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
              128'hb692cf0b643dbdf1be9bc5006830b3fe, 128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
              128'h47f7f7bc95353e03f96c32bcfd058dfd, 128'h3caaa3e8a99f9deb50f3af57adf622aa,
              128'h5e390f7df7a69296a7553dc10aa31f6b, 128'h14f9701ae35fe28c440adf4d4ea9c026,
              128'h47438735a41c65b9e016baf4aebf7ad2, 128'h549932d1f08557681093ed9cbe2c974e,
              128'h13111d7fe3944a17f307a78b4d2b30c5};
`endif
    rst_n   = 1'b0;
    dat     = '0;
    blocks  = '0;
    key_we  = 1'b0;
    key_idx = '0;
    key_dat = '0;
    for (int i = 0; i < 3; i++) begin
      vld[i] = 1'b0;
      rd[i]  = 1'b0;
    end

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 128'(ovld[0]), 128'(0));
    check("rst_busy", 128'(busy[0]), 128'(0));
    check("rst_dat", odat[0], 128'd0);
    check("rst_ready", 128'(rdy[0]), 128'(0));
    check("rst_state", 128'(dbg[0]), 128'(0));
    rst_n = 1'b1;
    #1;
    check("ready_first_cycle", 128'(rdy[0]), 128'(0));
    @(posedge clk); #1;
    check("ready_after", 128'(rdy[0]), 128'(1));

    // single zero block, zero key; i_blocks changed mid-chain is ignored
    send_word(0, 128'd0, 4'd0);
    blocks = 4'hf;
    check("t1_busy", 128'(busy[0]), 128'(1));
    check("t1_ready_low", 128'(rdy[0]), 128'(0));
    check("t1_state_sub", 128'(dbg[0]), 128'(1));
    exp_q.push_back(ZK1);
    wait_result(0, 20);
    check("t1_busy_end", 128'(busy[0]), 128'(0));
    read_out(0);

    // two zero blocks on every lane width
    for (int u = 0; u < 3; u++) begin
      send_word(u, 128'd0, 4'd1);
      send_word(u, 128'd0, 4'd1);
      exp_q.push_back(ZK2);
      wait_result(u, lat_of(u));
      read_out(u);
    end

    // seven idle cycles between blocks
    send_word(0, 128'd0, 4'd1);
    while (busy[0] && !rdy[0]) begin
      @(posedge clk); #1;
    end
    bad = 0;
    repeat (7) begin
      @(posedge clk); #1;
      if (!busy[0] || !rdy[0]) bad++;
    end
    check("t6_busy_gap", 128'(bad), 128'(0));
    send_word(0, 128'd0, 4'd1);
    exp_q.push_back(ZK2);
    wait_result(0, 20);

    // backpressure: hold result 50 cycles, then read + new word in one cycle
    held = odat[0];
    bad  = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (odat[0] !== held || rdy[0] || !ovld[0]) bad++;
    end
    check("t4_hold", 128'(bad), 128'(0));
    dat    = 128'd0;
    blocks = 4'd0;
    vld[0] = 1'b1;
    rd[0]  = 1'b1;
    #1;
    check("t4_ready_on_read", 128'(rdy[0]), 128'(1));
    @(posedge clk); #1;
    vld[0] = 1'b0;
    rd[0]  = 1'b0;
    check("t4_valid_drop", 128'(ovld[0]), 128'(0));
    check("t4_new_busy", 128'(busy[0]), 128'(1));
    exp_q.push_back(ZK1);
    wait_result(0, 20);
    read_out(0);

    // reset in the middle of block 1 of a 3-block chain
    send_word(0, 128'd0, 4'd2);
    send_word(0, 128'd0, 4'd2);
    check("t5_in_sub", 128'(dbg[0]), 128'(1));
    rst_n = 1'b0;
    #1;
    check("t5_rst_state", 128'(dbg[0]), 128'(0));
    check("t5_rst_busy", 128'(busy[0]), 128'(0));
    check("t5_rst_dat", odat[0], 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_word(0, 128'd0, 4'd0);
    exp_q.push_back(ZK1);
    wait_result(0, 20);
    read_out(0);

`ifdef AESPP_KEY_WR_EN
    // FIPS-197 key schedule loaded while idle, then writes during busy are dropped
    for (int k = 0; k < 11; k++) begin
      key_we  = 1'b1;
      key_idx = 4'(k);
      key_dat = c1_rk[k];
      @(posedge clk); #1;
    end
    key_we = 1'b0;
    send_word(0, 128'h00112233445566778899aabbccddeeff, 4'd0);
    check("t3_busy_at_write", 128'(busy[0]), 128'(1));
    key_we  = 1'b1;
    key_idx = 4'd5;
    key_dat = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    key_idx = 4'd10;
    @(posedge clk); #1;
    key_we = 1'b0;
    exp_q.push_back(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    wait_result(0, 20);
    read_out(0);
`endif

    check("sb_drain", 128'(exp_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
